video_output: RTL and testbench

Final pixel stage of the raster pipeline, between the shader chain and the VGA pins. It delays the timing signals (hsync, vsync, active, x, y) by a parameterised number of cycles so they line up with the shader colour output. It also blanks colour outside the active area and adds selectable test-pattern modes. Mode changes are latched only at frame start, so a frame never tears, and the block reports frame boundaries to the rest of the design.

---
 rtl/video_output.sv | 188 ++++++++++++++++++
 tb/tb_video_output.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_output.sv
// rtl/video_output.sv - timing delay line, colour blanking, test patterns and frame tracking for VGA output
module video_output #(
  parameter int COLOR_W         = 4,
  parameter int LATENCY         = 2,
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                 clk_pix,
  input  logic                 resetn,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic                 active_in,
  input  logic [9:0]           x_in,
  input  logic [9:0]           y_in,
  input  logic [COLOR_W-1:0]   r_in,
  input  logic [COLOR_W-1:0]   g_in,
  input  logic [COLOR_W-1:0]   b_in,
  input  logic [3*COLOR_W-1:0] solid_in,
  input  logic [1:0]           mode_in,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 vga_hsync,
  output logic                 vga_vsync,
  output logic [1:0]           mode_active,
  output logic                 frame_start,
  output logic [15:0]          frame_count
);

  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;
  localparam int   TW        = 23;
  localparam int   BAR_LEN   = H_ACTIVE / 8;
  localparam int   BAR_W     = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;
  localparam logic [TW-1:0] TIMING_RST = {SYNC_IDLE, SYNC_IDLE, 1'b0, 20'd0};

  logic [TW-1:0] timing_in;
  logic [TW-1:0] timing_dl;
  logic          hsync_dl, vsync_dl, active_dl;
  logic [9:0]    x_dl, y_dl;

  assign timing_in = {hsync_in, vsync_in, active_in, x_in, y_in};
  assign {hsync_dl, vsync_dl, active_dl, x_dl, y_dl} = timing_dl;

  generate
    if (LATENCY == 0) begin : g_no_delay
      assign timing_dl = timing_in;
    end else begin : g_delay
      logic [TW-1:0] pipe_q [LATENCY];
      logic [TW-1:0] pipe_d [LATENCY];

      // shift the timing bundle one stage per pixel clock
      always_comb begin
        pipe_d[0] = timing_in;
        for (int i = 1; i < LATENCY; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      // delay stages reset to idle sync, inactive, origin coordinates
      always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
          for (int i = 0; i < LATENCY; i++) pipe_q[i] <= TIMING_RST;
        end else begin
          for (int i = 0; i < LATENCY; i++) pipe_q[i] <= pipe_d[i];
        end
      end

      assign timing_dl = pipe_q[LATENCY-1];
    end
  endgenerate

  logic               vs_prev_q, vs_prev_d;
  logic [BAR_W-1:0]   bar_cnt_q, bar_cnt_d;
  logic [2:0]         bar_k_q, bar_k_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d;
  logic [1:0]         mode_q, mode_d;
  logic               fs_q, fs_d;
  logic [15:0]        fcnt_q, fcnt_d;
  logic               fs_det;
  logic [1:0]         mode_eff;
  logic               on_border;

  // frame start is the idle-to-asserted edge of the delayed vsync; the new mode applies on that same pixel
  always_comb begin
    fs_det    = (vsync_dl != SYNC_IDLE) && (vs_prev_q == SYNC_IDLE);
    mode_eff  = fs_det ? mode_in : mode_q;
    on_border = (x_dl == 10'd0) || (x_dl == 10'(H_ACTIVE - 1)) ||
                (y_dl == 10'd0) || (y_dl == 10'(V_ACTIVE - 1));
  end

  // bar counter runs only during active pixels; k saturates on the last (black) bar
  always_comb begin
    bar_cnt_d = bar_cnt_q;
    bar_k_d   = bar_k_q;
    if (!active_dl) begin
      bar_cnt_d = '0;
      bar_k_d   = 3'd0;
    end else if (bar_cnt_q == BAR_W'(BAR_LEN - 1)) begin
      bar_cnt_d = '0;
      if (bar_k_q != 3'd7) bar_k_d = bar_k_q + 3'd1;
    end else begin
      bar_cnt_d = bar_cnt_q + BAR_W'(1);
    end
  end

  // colour selection by mode, then blanking outside the active area
  always_comb begin
    r_d = r_in;
    g_d = g_in;
    b_d = b_in;
    case (mode_eff)
      2'd1: begin
        r_d = solid_in[3*COLOR_W-1:2*COLOR_W];
        g_d = solid_in[2*COLOR_W-1:COLOR_W];
        b_d = solid_in[COLOR_W-1:0];
      end
      2'd2: begin
        r_d = {COLOR_W{~bar_k_q[1]}};
        g_d = {COLOR_W{~bar_k_q[2]}};
        b_d = {COLOR_W{~bar_k_q[0]}};
      end
      2'd3: begin
        if (on_border) begin
          r_d = {COLOR_W{1'b1}};
          g_d = {COLOR_W{1'b1}};
          b_d = {COLOR_W{1'b1}};
        end
      end
      default: ;
    endcase
    if (!active_dl) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  // sync pass-through and frame bookkeeping for the output register
  always_comb begin
    hsync_d   = hsync_dl;
    vsync_d   = vsync_dl;
    vs_prev_d = vsync_dl;
    mode_d    = mode_eff;
    fs_d      = fs_det;
    fcnt_d    = fs_det ? fcnt_q + 16'd1 : fcnt_q;
  end

  // single output register stage plus bar and edge-detect state
  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hsync_q   <= SYNC_IDLE;
      vsync_q   <= SYNC_IDLE;
      vs_prev_q <= SYNC_IDLE;
      mode_q    <= 2'd0;
      fs_q      <= 1'b0;
      fcnt_q    <= 16'd0;
      bar_cnt_q <= '0;
      bar_k_q   <= 3'd0;
    end else begin
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      vs_prev_q <= vs_prev_d;
      mode_q    <= mode_d;
      fs_q      <= fs_d;
      fcnt_q    <= fcnt_d;
      bar_cnt_q <= bar_cnt_d;
      bar_k_q   <= bar_k_d;
    end
  end

  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign mode_active = mode_q;
  assign frame_start = fs_q;
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_video_output.sv
// tb/tb_video_output.sv - randomized bench with behavioural model for video_output
module tb_video_output;
  localparam int LAT = 2;
  localparam int HA  = 640;
  localparam int VA  = 480;
  localparam int LINE_LEN = 660;

  logic        clk_pix = 1'b0;
  logic        resetn;
  logic        hsync_in, vsync_in, active_in;
  logic [9:0]  x_in, y_in;
  logic [3:0]  r_in, g_in, b_in;
  logic [11:0] solid_in;
  logic [1:0]  mode_in;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync;
  logic [1:0]  mode_active;
  logic        frame_start;
  logic [15:0] frame_count;

  always #5 clk_pix = ~clk_pix;

  video_output #(.COLOR_W(4), .LATENCY(LAT), .H_ACTIVE(HA), .V_ACTIVE(VA), .SYNC_ACTIVE_LOW(1'b1)) dut (
    .clk_pix(clk_pix), .resetn(resetn),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .active_in(active_in),
    .x_in(x_in), .y_in(y_in), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .solid_in(solid_in), .mode_in(mode_in),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .mode_active(mode_active), .frame_start(frame_start), .frame_count(frame_count)
  );

  // input history, indexed by driven cycle
  logic        h_hist [0:65535];
  logic        v_hist [0:65535];
  logic        a_hist [0:65535];
  logic [9:0]  x_hist [0:65535];
  logic [9:0]  y_hist [0:65535];
  logic [11:0] c_hist [0:65535];
  logic [11:0] s_hist [0:65535];
  logic [1:0]  m_hist [0:65535];

  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
  logic [11:0] cap  [0:1023];

  int          cyc = 0;
  int          base = 1;
  int          n_pass = 0;
  int          n_total = 0;
  bit          model_en = 1'b0;
  bit          rel_pending = 1'b0;
  bit          zero_col = 1'b0;
  bit          col_ovr_en = 1'b0;
  logic [11:0] col_ovr = 12'h000;
  logic [1:0]  mode_req = 2'd0;
  logic [1:0]  mdl_mode = 2'd0;
  logic [15:0] mdl_fc = 16'd0;
  int          run = 0;
  int          fs_seen = 0;
  logic [1:0]  last_fs_mode = 2'd0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic drive(input logic hs, input logic vs, input logic act, input logic [9:0] x, input logic [9:0] y);
    logic [11:0] c;
    @(negedge clk_pix);
    if (rel_pending) begin
      resetn = 1'b1;
      rel_pending = 1'b0;
    end
    c = zero_col ? 12'h000 : (col_ovr_en ? col_ovr : 12'($urandom));
    hsync_in = hs; vsync_in = vs; active_in = act; x_in = x; y_in = y;
    {r_in, g_in, b_in} = c;
    solid_in = 12'($urandom);
    mode_in = mode_req;
    cyc = cyc + 1;
    h_hist[cyc] = hs; v_hist[cyc] = vs; a_hist[cyc] = act;
    x_hist[cyc] = x;  y_hist[cyc] = y;  c_hist[cyc] = c;
    s_hist[cyc] = solid_in; m_hist[cyc] = mode_req;
  endtask

  task automatic line(input logic [9:0] y, input bit act_line, input bit vs_on);
    for (int x = 0; x < LINE_LEN; x++)
      drive((x >= 648 && x < 656) ? 1'b0 : 1'b1, vs_on ? 1'b0 : 1'b1, act_line && (x < HA), 10'(x), y);
  endtask

  // kind: 0 plain, 2 bars, 3 border, 4 random mode per line
  task automatic frame(input int kind, input logic [1:0] next_mode);
    logic [9:0] y;
    if (kind == 4) mode_req = 2'($urandom_range(0, 3));
    line(10'd0, 1'b0, 1'b1);
    line(10'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      y = (i == 0) ? 10'd0 : (i == 1) ? 10'd5 : 10'(VA - 1);
      if (kind == 4) mode_req = 2'($urandom_range(0, 3));
      line(y, 1'b1, 1'b0);
      if (i == 0 && kind != 4) mode_req = next_mode;
      if (kind == 2 && i == 0) begin
        chk("bar_px0",   32'(cap[0]),   32'h0FFF);
        chk("bar_px79",  32'(cap[79]),  32'h0FFF);
        chk("bar_px80",  32'(cap[80]),  32'h0FF0);
        chk("bar_px400", 32'(cap[400]), 32'h0F00);
        chk("bar_px639", 32'(cap[639]), 32'h0000);
      end
      if (kind == 2 && i == 1) chk("bar_restart", 32'(cap[0]), 32'h0FFF);
      if (kind == 3 && i == 0) chk("border_y0", 32'(cap[300]), 32'h0FFF);
      if (kind == 3 && i == 1) begin
        chk("border_x0",   32'(cap[0]),   32'h0FFF);
        chk("border_x639", 32'(cap[639]), 32'h0FFF);
        chk("border_5_5",  32'(cap[5]),   32'h0000);
      end
      if (kind == 3 && i == 2) chk("border_y479", 32'(cap[300]), 32'h0FFF);
    end
  endtask

  task automatic model_restart();
    base = cyc + 1;
    mdl_mode = 2'd0;
    mdl_fc = 16'd0;
    run = 0;
  endtask

  // behavioural model: output at cycle n reflects timing from n-LAT and colour/mode inputs from n
  always @(posedge clk_pix) begin : cmp
    int m;
    int k;
    logic hm, vm, vm1, am, efs, border;
    logic [9:0] xm, ym;
    logic [11:0] ec, gc, ci;
    #2;
    if (model_en) begin
      m   = cyc - LAT;
      hm  = (m >= base) ? h_hist[m] : 1'b1;
      vm  = (m >= base) ? v_hist[m] : 1'b1;
      am  = (m >= base) ? a_hist[m] : 1'b0;
      xm  = (m >= base) ? x_hist[m] : 10'd0;
      ym  = (m >= base) ? y_hist[m] : 10'd0;
      vm1 = (m - 1 >= base) ? v_hist[m-1] : 1'b1;
      efs = vm1 && !vm;
      if (efs) begin
        mdl_mode = m_hist[cyc];
        mdl_fc = mdl_fc + 16'd1;
      end
      ci = c_hist[cyc];
      border = (xm == 10'd0) || (xm == 10'(HA - 1)) || (ym == 10'd0) || (ym == 10'(VA - 1));
      if (!am) begin
        ec = 12'h000;
        run = 0;
      end else begin
        k = run / (HA / 8);
        if (k > 7) k = 7;
        run++;
        case (mdl_mode)
          2'd0: ec = ci;
          2'd1: ec = s_hist[cyc];
          2'd2: ec = bars[k];
          default: ec = border ? 12'hFFF : ci;
        endcase
      end
      gc = {vga_r, vga_g, vga_b};
      chk("colour", 32'(gc), 32'(ec));
      chk("ctrl", {11'b0, vga_hsync, vga_vsync, mode_active, frame_start, frame_count},
                  {11'b0, hm, vm, mdl_mode, efs, mdl_fc});
      if (am) cap[xm] = gc;
      if (frame_start) begin
        fs_seen++;
        last_fs_mode = mode_active;
      end
    end
  end

  initial begin
    resetn = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; active_in = 1'b0;
    x_in = '0; y_in = '0; r_in = '0; g_in = '0; b_in = '0; solid_in = '0; mode_in = '0;
    repeat (3) drive(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
    #1;
    chk("rst_rgb",   32'({vga_r, vga_g, vga_b}), 32'h0);
    chk("rst_syncs", 32'({vga_hsync, vga_vsync}), 32'h3);
    chk("rst_fcnt",  32'(frame_count), 32'h0);
    chk("rst_mode",  32'(mode_active), 32'h0);

    model_restart();
    rel_pending = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
    model_en = 1'b1;

    // latency alignment in pass mode
    col_ovr_en = 1'b1;
    col_ovr = 12'h000; drive(1'b1, 1'b1, 1'b1, 10'd0, 10'd0);
    drive(1'b1, 1'b1, 1'b0, 10'd1, 10'd0);
    col_ovr = 12'hA00; drive(1'b1, 1'b1, 1'b0, 10'd2, 10'd0);
    @(posedge clk_pix); #1;
    chk("lat_r", 32'(vga_r), 32'hA);
    col_ovr = 12'hF00; drive(1'b1, 1'b1, 1'b0, 10'd3, 10'd0);
    @(posedge clk_pix); #1;
    chk("blank_r", 32'(vga_r), 32'h0);
    col_ovr_en = 1'b0;

    mode_req = 2'd0;
    frame(0, 2'd1);
    frame(0, 2'd2);
    chk("latch_mode", 32'(last_fs_mode), 32'h1);
    frame(2, 2'd3);
    chk("fs_pulses", 32'(fs_seen), 32'h3);
    chk("fcnt_3", 32'(frame_count), 32'h3);
    zero_col = 1'b1;
    frame(3, 2'd0);
    zero_col = 1'b0;
    frame(4, 2'd0);
    frame(4, 2'd0);

    // asynchronous reset mid-line with active high
    for (int x = 0; x < 100; x++) drive(1'b1, 1'b1, 1'b1, 10'(x), 10'd10);
    #2;
    model_en = 1'b0;
    resetn = 1'b0;
    #1;
    chk("arst_rgb",   32'({vga_r, vga_g, vga_b}), 32'h0);
    chk("arst_syncs", 32'({vga_hsync, vga_vsync}), 32'h3);
    chk("arst_fcnt",  32'(frame_count), 32'h0);
    chk("arst_mode",  32'(mode_active), 32'h0);
    chk("arst_fs",    32'(frame_start), 32'h0);
    repeat (3) drive(1'b1, 1'b1, 1'b1, 10'd0, 10'd10);
    model_restart();
    rel_pending = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
    model_en = 1'b1;

    frame(4, 2'd0);
    force dut.fcnt_q = 16'hFFFE;
    mdl_fc = 16'hFFFE;
    #1;
    release dut.fcnt_q;
    frame(4, 2'd0);
    frame(4, 2'd0);
    chk("fcnt_wrap", 32'(frame_count), 32'h0);
    frame(4, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
